// File: rtl/proc_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : proc_bus_master
//  Purpose  : Processor-side master of the shared main bus. Accepts one
//             4-word burst request at a time from the core. For each burst it
//             runs one address cycle followed by four data cycles, then
//             returns read data or completion status. Requests to pages with
//             no memory slave are rejected locally, with no bus traffic.
//  Ports    : clk, resetN (async active-low)
//             req_*  : core request channel (valid/ready), 64-bit write data
//             resp_* : core response channel (valid/ready), error flag and
//                      64-bit read data
//             bus_*  : main-bus AddrValid, rw, AddrData out/oe/in
//  Revision : 1.0  initial release
// ============================================================================
module proc_bus_master #(
    parameter logic [15:0] PAGE_MAP = 16'h0004,
    parameter int          RD_DELAY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic        bus_addrvalid,
    output logic        bus_rw,
    output logic [15:0] bus_ad_o,
    output logic        bus_ad_oe,
    input  logic [15:0] bus_ad_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_DATA = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_rw;
    logic [63:0] r_wsh;     // write words, shifted down one word per beat
    logic [47:0] r_rbuf;    // first three read words; the fourth comes straight off the bus
    logic [1:0]  r_beat;
    logic [1:0]  r_wcnt;    // remaining WAIT cycles minus one

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_IDLE;
            r_rw          <= 1'b1;
            r_wsh         <= 64'h0;
            r_rbuf        <= 48'h0;
            r_beat        <= 2'd0;
            r_wcnt        <= 2'd0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= 64'h0;
            bus_addrvalid <= 1'b0;
            bus_rw        <= 1'b1;
            bus_ad_o      <= 16'h0;
            bus_ad_oe     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // req_ready is high throughout IDLE, so req_valid alone is the handshake
                    if (req_valid) begin
                        r_rw      <= req_rw;
                        r_wsh     <= req_wdata;
                        req_ready <= 1'b0;
                        if (PAGE_MAP[req_addr[15:12]]) begin
                            r_state       <= S_ADDR;
                            bus_addrvalid <= 1'b1;
                            bus_rw        <= req_rw;
                            bus_ad_o      <= req_addr;
                            bus_ad_oe     <= 1'b1;
                        end else begin
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 64'h0;
                        end
                    end
                end

                S_ADDR: begin
                    bus_addrvalid <= 1'b0;
                    r_beat        <= 2'd0;
                    if (!r_rw) begin
                        r_state  <= S_DATA;
                        bus_ad_o <= r_wsh[15:0];
                        r_wsh    <= {16'h0, r_wsh[63:16]};
                    end else begin
                        // release AddrData before the slave may start driving it
                        bus_ad_oe <= 1'b0;
                        bus_ad_o  <= 16'h0;
                        if (RD_DELAY <= 1) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_WAIT;
                            r_wcnt  <= 2'(RD_DELAY - 2);
                        end
                    end
                end

                S_WAIT: begin
                    if (r_wcnt == 2'd0) begin
                        r_state <= S_DATA;
                    end else begin
                        r_wcnt <= r_wcnt - 2'd1;
                    end
                end

                S_DATA: begin
                    r_beat <= r_beat + 2'd1;
                    if (r_rw) begin
                        r_rbuf <= {bus_ad_i, r_rbuf[47:16]};
                    end else begin
                        bus_ad_o <= r_wsh[15:0];
                        r_wsh    <= {16'h0, r_wsh[63:16]};
                    end
                    if (r_beat == 2'd3) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= r_rw ? {bus_ad_i, r_rbuf} : 64'h0;
                        bus_ad_oe  <= 1'b0;
                        bus_rw     <= 1'b1;
                        bus_ad_o   <= 16'h0;
                    end
                end

                S_RESP: begin
                    if (resp_ready) begin
                        r_state    <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 64'h0;
                        req_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    req_ready     <= 1'b1;
                    resp_valid    <= 1'b0;
                    bus_addrvalid <= 1'b0;
                    bus_ad_oe     <= 1'b0;
                    bus_rw        <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_proc_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_proc_bus_master
//  Purpose  : Self-checking bench for proc_bus_master. A behavioural memory
//             slave sits on the bus; a word-addressed reference memory
//             predicts read data. Expected responses and bus bursts are
//             queued at issue time and checked by a separate monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_proc_bus_master;

    localparam logic [15:0] P_MAP = 16'h8004;   // pages 2 and 15 populated
    localparam int          P_RDD = 1;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_rw;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        bus_addrvalid, bus_rw, bus_ad_oe;
    logic [15:0] bus_ad_o, bus_ad_i;

    typedef struct packed {logic err; logic [63:0] rdata;} resp_t;
    typedef struct packed {logic rw; logic [15:0] addr; logic [63:0] wdata;} burst_t;

    resp_t       resp_q[$];
    burst_t      bus_q[$];
    logic [15:0] ref_mem [int];
    int          checks = 0;
    int          errors = 0;
    logic        final_chk = 1'b0;

    proc_bus_master #(.PAGE_MAP(P_MAP), .RD_DELAY(P_RDD)) dut (
        .clk(clk), .resetN(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .bus_addrvalid(bus_addrvalid), .bus_rw(bus_rw), .bus_ad_o(bus_ad_o),
        .bus_ad_oe(bus_ad_oe), .bus_ad_i(bus_ad_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural memory slave ----------------
    logic [15:0] smem [0:65535];
    logic        s_act, s_rw;
    logic [15:0] s_base;
    logic [1:0]  s_beat;
    int          s_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_act <= 1'b0;
        end else if (bus_addrvalid) begin
            s_act  <= 1'b1;
            s_rw   <= bus_rw;
            s_base <= bus_ad_o;
            s_wait <= bus_rw ? P_RDD - 1 : 0;
            s_beat <= 2'd0;
        end else if (s_act) begin
            if (s_wait > 0) begin
                s_wait <= s_wait - 1;
            end else begin
                if (!s_rw) smem[s_base + 16'(s_beat)] <= bus_ad_o;
                s_beat <= s_beat + 2'd1;
                if (s_beat == 2'd3) s_act <= 1'b0;
            end
        end
    end

    assign bus_ad_i = (s_act && s_rw && s_wait == 0) ? smem[s_base + 16'(s_beat)] : 16'hBAD0;

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    int     cyc_idx = 0;
    burst_t cur;
    logic   exp_err_next = 1'b0;
    logic   stab_v = 1'b0;
    resp_t  stab, exp_r;
    int     nwait, kb;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_ctrl", 64'({req_ready, resp_valid, resp_err, bus_addrvalid, bus_rw, bus_ad_oe}),
                64'(6'b100010));
            chk("reset_rdata", resp_rdata, 64'h0);
            chk("reset_ad_o", 64'(bus_ad_o), 64'h0);
            cyc_idx = 0;
            bus_q.delete();
            exp_err_next = 1'b0;
            stab_v = 1'b0;
        end else begin
            // response channel
            if (exp_err_next) chk("unmapped_resp_next_cycle", 64'({resp_valid, resp_err}), 64'(2'b11));
            exp_err_next = 1'b0;
            if (resp_valid) begin
                chk("req_ready_low_in_resp", 64'(req_ready), 64'h0);
                if (stab_v) chk("resp_stable", 65'({resp_err, resp_rdata}), 65'(stab));
            end
            if (resp_valid && resp_ready) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", 64'(resp_valid), 64'h0);
                end else begin
                    exp_r = resp_q.pop_front();
                    chk("resp_err", 64'(resp_err), 64'(exp_r.err));
                    chk("resp_rdata", resp_rdata, exp_r.rdata);
                end
                stab_v = 1'b0;
            end else if (resp_valid) begin
                stab   = '{resp_err, resp_rdata};
                stab_v = 1'b1;
            end else begin
                stab_v = 1'b0;
            end
            if (req_valid && req_ready) exp_err_next = !P_MAP[req_addr[15:12]];

            // bus channel
            if (cyc_idx == 0) begin
                if (bus_addrvalid) begin
                    if (bus_q.size() == 0) begin
                        chk("unexpected_addrvalid", 64'(bus_addrvalid), 64'h0);
                    end else begin
                        cur = bus_q.pop_front();
                        chk("addr_cycle", 64'({bus_rw, bus_ad_oe, bus_ad_o}), 64'({cur.rw, 1'b1, cur.addr}));
                        cyc_idx = 1;
                    end
                end else begin
                    chk("bus_idle", 64'({bus_ad_oe, bus_rw}), 64'(2'b01));
                end
            end else begin
                nwait = cur.rw ? P_RDD - 1 : 0;
                if (cyc_idx <= nwait) begin
                    chk("wait_cycle", 64'({bus_addrvalid, bus_ad_oe}), 64'h0);
                end else begin
                    kb = cyc_idx - 1 - nwait;
                    chk("data_ctrl", 64'({bus_addrvalid, bus_rw, bus_ad_oe}), 64'({1'b0, cur.rw, !cur.rw}));
                    if (!cur.rw) chk("write_word", 64'(bus_ad_o), 64'(cur.wdata[16*kb +: 16]));
                end
                cyc_idx++;
                if (cyc_idx > nwait + 4) cyc_idx = 0;
            end
        end
        if (final_chk) chk("queues_drained", 64'(resp_q.size() + bus_q.size()), 64'h0);
    end

    // ---------------- reference model helpers ----------------
    function automatic bit page_ok(input logic [15:0] a);
        logic [15:0] m;
        m = P_MAP;
        return m[a[15:12]];
    endfunction

    function automatic bit all_valid(input logic [15:0] a);
        logic [15:0] w;
        for (int k = 0; k < 4; k++) begin
            w = a + 16'(k);
            if (!ref_mem.exists(int'(w))) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive_accept(input bit rw, input logic [15:0] a, input logic [63:0] wd, input bit pre);
        bit rdy, acc;
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd; resp_ready = pre;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy) begin acc = 1'b1; break; end
        end
        if (!acc) begin
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
            $fatal(1);
        end
        // scramble request fields: the DUT must have latched them already
        req_valid = 1'b0; req_rw = 1'($urandom); req_addr = 16'($urandom);
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic txn(input bit rw, input logic [15:0] a, input logic [63:0] wd, input int hold, input bit pre);
        resp_t r;
        logic [15:0] w;
        int h;
        bit hs, done;
        r = '0;
        if (!page_ok(a)) begin
            r.err = 1'b1;
        end else begin
            bus_q.push_back('{rw, a, wd});
            for (int k = 0; k < 4; k++) begin
                w = a + 16'(k);
                if (!rw) ref_mem[int'(w)] = wd[16*k +: 16];
                else     r.rdata[16*k +: 16] = ref_mem[int'(w)];
            end
        end
        resp_q.push_back(r);
        drive_accept(rw, a, wd, pre);
        h = hold; done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (resp_valid) begin
                if (h > 0 && !resp_ready) h--;
                else resp_ready = 1'b1;
            end
            hs = resp_valid && resp_ready;
            @(posedge clk); #1;
            if (hs) begin done = 1'b1; break; end
        end
        if (!done) begin
            $display("FAIL resp_timeout: resp_valid=%b required handshake", resp_valid);
            $fatal(1);
        end
        resp_ready = 1'b0;
    endtask

    // write to page 2, then pull reset during data beat 2
    task automatic reset_mid_write(input logic [15:0] a, input logic [63:0] wd);
        logic [15:0] w;
        bus_q.push_back('{1'b0, a, wd});
        drive_accept(1'b0, a, wd, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = a + 16'(k);
            ref_mem.delete(int'(w));
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          rw;
        logic [15:0] a;
        rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        txn(1'b0, 16'h2010, 64'h4444_3333_2222_1111, 0, 1'b0);
        txn(1'b1, 16'h2010, 64'h0, 0, 1'b0);
        txn(1'b1, 16'h5000, 64'h0, 0, 1'b0);
        txn(1'b1, 16'h2010, 64'h0, 5, 1'b0);
        txn(1'b0, 16'hFFFE, 64'hDDDD_CCCC_BBBB_AAAA, 0, 1'b1);
        txn(1'b1, 16'hFFFE, 64'h0, 0, 1'b1);
        reset_mid_write(16'h2F00, 64'h8888_7777_6666_5555);
        @(posedge clk); #1;
        txn(1'b0, 16'h2020, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
        txn(1'b1, 16'h2020, 64'h0, 1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom % 4)
                0: a = 16'h2000 + 16'($urandom % 32);
                1: a = 16'hFFE0 + 16'($urandom % 32);
                2: a = 16'h5000 + 16'($urandom % 16);
                default: a = 16'h0100 + 16'($urandom % 16);
            endcase
            rw = 1'($urandom);
            if (rw && page_ok(a) && !all_valid(a)) rw = 1'b0;
            txn(rw, a, {$urandom, $urandom}, int'($urandom % 4), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        final_chk = 1'b1;
        @(posedge clk);
        final_chk = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proc_bus_master.md
Name: proc_bus_master

Overview:
- Processor-side master of the shared main bus; sits directly upstream of the per-page memory slave interfaces.
- Accepts single 4-word burst requests from the processor core and runs the main-bus protocol:
  - one address cycle;
  - then four consecutive data cycles, written from the master or read from the slave.
- Returns read data or completion status to the core.
- Requests to pages with no slave are rejected locally with an error and no bus traffic.

Parameters:
- PAGE_MAP, 16'h0004, bitmap of populated pages; bit n=1 means page n (addr[15:12]==n) has a memory slave (default: page 2 only).
- RD_DELAY, 1, cycles from the address cycle to the first read data beat (range 1..3).

Ports:
- clk  in  1  bus clock
- resetN  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  master can accept a request
- req_rw  in  1  1=read burst, 0=write burst
- req_addr  in  16  burst base address
- req_wdata  in  64  write words; word k = bits [16k+15:16k], written to base+k
- resp_valid  out  1  response available
- resp_ready  in  1  core accepts response
- resp_err  out  1  1 = unmapped page, no bus access performed
- resp_rdata  out  64  read words, same packing as req_wdata; 0 for writes/errors
- bus_addrvalid  out  1  main-bus AddrValid
- bus_rw  out  1  main-bus rw
- bus_ad_o  out  16  value driven onto AddrData
- bus_ad_oe  out  1  AddrData output enable (tri-state control at top level)
- bus_ad_i  in  16  sampled AddrData

Behaviour:
- Reset (resetN low, async): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; bus_addrvalid=0; bus_rw=1; bus_ad_o=0; bus_ad_oe=0. Reset mid-burst abandons the burst immediately; no response is produced.
- Handshake: a request is accepted on a clk edge with req_valid&&req_ready. req_ready=1 only in IDLE. req_rw, req_addr and req_wdata are registered at acceptance; later changes are ignored.
- States: IDLE, ADDR, WAIT, DATA, RESP.
- IDLE -> ADDR on acceptance if PAGE_MAP[req_addr[15:12]]=1.
- IDLE -> RESP directly on acceptance if the page is unmapped. resp_err=1, resp_rdata=0, bus untouched.
- ADDR (1 cycle): bus_addrvalid=1, bus_rw=latched rw, bus_ad_o=base address, bus_ad_oe=1.
  - Write -> DATA.
  - Read -> DATA if RD_DELAY==1, else WAIT.
- WAIT (reads only, RD_DELAY-1 cycles): bus_ad_oe=0, bus_addrvalid=0.
- DATA (exactly 4 cycles, 2-bit beat counter k=0..3): bus_addrvalid=0; bus_rw holds the latched value.
  - Write: bus_ad_oe=1, bus_ad_o=word k.
  - Read: bus_ad_oe=0; bus_ad_i is sampled into word k at the end of each beat.
  - After k=3 -> RESP.
- RESP: resp_valid=1 with stable resp_err/resp_rdata until resp_ready. Leaves to IDLE on the edge where resp_ready=1; resp_valid drops the next cycle. A resp_ready already high on entry completes in 1 cycle.
- Bus idle value (IDLE/RESP): addrvalid=0, oe=0, rw=1.
- The master never drives AddrData in any cycle the slave may drive it: read WAIT/DATA cycles.
- Address arithmetic belongs to the slave: base+k wraps mod 2^16. The page is decided by the base address only; bursts crossing a page boundary are not split or flagged.
- No back-to-back bursts: at least one IDLE cycle (req_ready=1) between RESP exit and the next ADDR.
- No timeout: a mapped-page read with an absent slave returns whatever bus_ad_i shows.

Test Plan:
- Write burst: req rw=0 addr=16'h2010 wdata=64'h4444_3333_2222_1111 ->
  - ADDR cycle with addrvalid=1, rw=0, ad_o=2010;
  - then ad_o 1111, 2222, 3333, 4444 with oe=1;
  - resp_valid with err=0.
  - Memory page 2 holds those values at 2010..2013.
- Read burst (RD_DELAY=1): after the write, req rw=1 addr=16'h2010 ->
  - oe=0 for 4 data cycles;
  - resp_rdata=64'h4444_3333_2222_1111, err=0.
- Unmapped page: req addr=16'h5000 -> resp_valid the cycle after acceptance, err=1, rdata=0, addrvalid never asserted.
- Response backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid/rdata stable, req_ready=0. Raise resp_ready -> return to IDLE, next request accepted.
- Wrap: write addr=16'hFFFE with page 15 mapped -> data lands at FFFE, FFFF, 0000, 0001.
- Reset mid-burst: assert resetN=0 during DATA beat k=2 of a write -> oe=0 and addrvalid=0 immediately (asynchronously), no resp_valid. After release, a new request completes normally.
